// File: rtl/uart_cmd_decoder_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_decoder_pkg
// Shared UART command constants: the frame SYNC byte, the decoder state
// encodings and the default widths used by uart_cmd_decoder and its timeout.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package uart_cmd_decoder_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam int DEF_WIDTH_DATABITS    = 8;
  localparam int DEF_WIDTH_CONFIG_ADDR = 4;
  localparam int DEF_WIDTH_CONFIG_DATA = 8;
  localparam int DEF_WIDTH_ERROR       = 2;
  localparam int DEF_TIMEOUT_CYCLES    = 100000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHK   = 3'd3,
    ST_ISSUE = 3'd4
  } cmd_state_e;

endpackage

// File: rtl/uart_cmd_timeout.sv
// -----------------------------------------------------------------------------
// uart_cmd_timeout
// Inter-byte watchdog. Counts clk cycles while enabled; restart clears it.
// expired is high in the TIMEOUT_CYCLES-th consecutive enabled cycle without a
// restart, so a byte arriving in that same cycle still wins.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   restart   - a byte arrived this cycle; clear the count
//   enable    - a frame is being collected
//   expired   - timeout reached this cycle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || !enable) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = enable && !restart && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_decoder.sv
// -----------------------------------------------------------------------------
// uart_cmd_decoder
// Decodes SYNC(A5), ADDR, DATA[, CHK] byte frames from a UART receiver into
// single config-bus writes with a valid/ready handshake.
// Optional feature macro: UART_CMD_CHECKSUM_EN -- when defined the frame has a
// fourth byte that must equal ADDR^DATA^A5; otherwise DATA goes straight to
// ISSUE.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   in_data, in_valid      - received byte and its one-cycle strobe
//   in_error, in_error_valid - receiver error code and its strobe
//   c_addr, c_data, c_valid, c_ready - config write handshake
//   frame_err              - one-cycle pulse per aborted frame
//   err_count              - saturating aborted-frame count
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int WIDTH_DATABITS    = DEF_WIDTH_DATABITS,
  parameter int WIDTH_CONFIG_ADDR = DEF_WIDTH_CONFIG_ADDR,
  parameter int WIDTH_CONFIG_DATA = DEF_WIDTH_CONFIG_DATA,
  parameter int WIDTH_ERROR       = DEF_WIDTH_ERROR,
  parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH_DATABITS-1:0]    in_data,
  input  logic                         in_valid,
  input  logic [WIDTH_ERROR-1:0]       in_error,
  input  logic                         in_error_valid,
  output logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
  output logic [WIDTH_CONFIG_DATA-1:0] c_data,
  output logic                         c_valid,
  input  logic                         c_ready,
  output logic                         frame_err,
  output logic [7:0]                   err_count
);

  localparam logic [WIDTH_DATABITS-1:0] SYNC_W = WIDTH_DATABITS'(SYNC_BYTE);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  cmd_state_e state;
  logic       in_frame;
  logic       byte_ok;
  logic       expired;
  logic       abort;

  // The error code itself is not interpreted: any error strobe aborts.
  logic unused_err;
  assign unused_err = ^in_error;

`ifdef UART_CMD_CHECKSUM_EN
  logic [WIDTH_DATABITS-1:0] addr_byte;
  logic [WIDTH_DATABITS-1:0] data_byte;
  logic                      chk_ok;
  assign chk_ok = (in_data == (addr_byte ^ data_byte ^ SYNC_W));
`else
  logic [WIDTH_CONFIG_ADDR-1:0] addr_byte;
`endif

  assign in_frame = (state == ST_ADDR) || (state == ST_DATA) || (state == ST_CHK);
  // An error strobe in the same cycle discards the byte.
  assign byte_ok  = in_valid && !in_error_valid;

  always_comb begin
    abort = 1'b0;
    if (in_frame && (in_error_valid || expired)) abort = 1'b1;
    // A byte during ISSUE is dropped but the pending write is kept.
    if ((state == ST_ISSUE) && in_valid) abort = 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
    if ((state == ST_CHK) && byte_ok && !chk_ok) abort = 1'b1;
`endif
  end

  uart_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .restart(in_valid),
    .enable (in_frame),
    .expired(expired)
  );

  // Frame byte capture (data path, no reset needed)
  always_ff @(posedge clk) begin
    if ((state == ST_ADDR) && byte_ok) begin
`ifdef UART_CMD_CHECKSUM_EN
      addr_byte <= in_data;
`else
      addr_byte <= in_data[WIDTH_CONFIG_ADDR-1:0];
`endif
    end
`ifdef UART_CMD_CHECKSUM_EN
    if ((state == ST_DATA) && byte_ok) data_byte <= in_data;
`endif
  end

  // Frame FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      c_valid   <= 1'b0;
      c_addr    <= '0;
      c_data    <= '0;
      frame_err <= 1'b0;
      err_count <= 8'd0;
    end else begin
      frame_err <= abort;
      if (abort) err_count <= sat_inc(err_count);
      case (state)
        ST_IDLE: begin
          if (byte_ok && (in_data == SYNC_W)) state <= ST_ADDR;
        end
        ST_ADDR: begin
          if (abort)        state <= ST_IDLE;
          else if (byte_ok) state <= ST_DATA;
        end
        ST_DATA: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (byte_ok) begin
`ifdef UART_CMD_CHECKSUM_EN
            state <= ST_CHK;
`else
            state   <= ST_ISSUE;
            c_valid <= 1'b1;
            c_addr  <= addr_byte;
            c_data  <= in_data[WIDTH_CONFIG_DATA-1:0];
`endif
          end
        end
        ST_CHK: begin
`ifdef UART_CMD_CHECKSUM_EN
          if (abort) begin
            state <= ST_IDLE;
          end else if (byte_ok) begin
            state   <= ST_ISSUE;
            c_valid <= 1'b1;
            c_addr  <= addr_byte[WIDTH_CONFIG_ADDR-1:0];
            c_data  <= data_byte[WIDTH_CONFIG_DATA-1:0];
          end
`else
          state <= ST_IDLE;
`endif
        end
        ST_ISSUE: begin
          if (c_ready) begin
            state   <= ST_IDLE;
            c_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_decoder
// Directed frames plus randomized byte/error/ready traffic, every cycle checked
// against a queue-based frame model. Honours UART_CMD_CHECKSUM_EN like the DUT.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_cmd_decoder;

  localparam int TMO = 40;
`ifdef UART_CMD_CHECKSUM_EN
  localparam int FRAME_LEN = 4;
`else
  localparam int FRAME_LEN = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic [1:0] in_error = 2'b00;
  logic       in_error_valid = 1'b0;
  logic [3:0] c_addr;
  logic [7:0] c_data;
  logic       c_valid;
  logic       c_ready = 1'b1;
  logic       frame_err;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_cmd_decoder #(
    .WIDTH_DATABITS(8), .WIDTH_CONFIG_ADDR(4), .WIDTH_CONFIG_DATA(8),
    .WIDTH_ERROR(2), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_error(in_error), .in_error_valid(in_error_valid),
    .c_addr(c_addr), .c_data(c_data), .c_valid(c_valid), .c_ready(c_ready),
    .frame_err(frame_err), .err_count(err_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] fq[$];     // bytes collected of the frame in progress
  bit         m_busy;    // a write is being offered
  logic [3:0] m_addr;
  logic [7:0] m_data;
  bit         m_ferr;
  int         m_errs;
  int         m_gap;     // cycles since the last byte of the open frame

  task automatic model_reset();
    fq.delete();
    m_busy = 0; m_addr = 4'h0; m_data = 8'h00;
    m_ferr = 0; m_errs = 0; m_gap = 0;
  endtask

  task automatic model_abort();
    fq.delete();
    m_ferr = 1;
    if (m_errs < 255) m_errs++;
  endtask

  task automatic model_step();
    m_ferr = 0;
    if (m_busy) begin
      if (in_valid) model_abort();
      if (c_ready) m_busy = 0;
    end else if (fq.size() == 0) begin
      if (in_valid && !in_error_valid && in_data == 8'hA5) begin
        fq.push_back(in_data);
        m_gap = 0;
      end
    end else if (in_error_valid) begin
      model_abort();
    end else if (in_valid) begin
      fq.push_back(in_data);
      m_gap = 0;
      if (fq.size() == FRAME_LEN) begin
        if (FRAME_LEN == 4 && in_data != (fq[1] ^ fq[2] ^ 8'hA5)) begin
          model_abort();
        end else begin
          m_busy = 1;
          m_addr = fq[1][3:0];
          m_data = fq[2];
          fq.delete();
        end
      end
    end else begin
      m_gap++;
      if (m_gap >= TMO) model_abort();
    end
  endtask

  // ---------------- stimulus helpers ----------------
  bit rand_ready = 0;
  int n_cv = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check_eq("c_valid",   32'(c_valid),   32'(m_busy));
    check_eq("c_addr",    32'(c_addr),    32'(m_addr));
    check_eq("c_data",    32'(c_data),    32'(m_data));
    check_eq("frame_err", 32'(frame_err), 32'(m_ferr));
    check_eq("err_count", 32'(err_count), m_errs);
    if (c_valid) n_cv++;
    @(negedge clk);
    in_valid = 1'b0;
    in_error_valid = 1'b0;
    if (rand_ready) c_ready = ($urandom_range(0, 99) < 60);
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
  endtask

  task automatic send_err();
    in_error_valid = 1'b1;
    in_error = 2'($urandom);
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] k);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(d);
    if (FRAME_LEN == 4) send_byte(k);
  endtask

  // Asynchronous reset between clock edges; outputs must clear before any edge.
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check_eq({tag, "_c_valid"},   32'(c_valid),   32'h0);
    check_eq({tag, "_c_addr"},    32'(c_addr),    32'h0);
    check_eq({tag, "_c_data"},    32'(c_data),    32'h0);
    check_eq({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    check_eq({tag, "_err_count"}, 32'(err_count), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int err0, sel, gap;
    logic [7:0] fb[4];

    model_reset();
    @(negedge clk);
    do_reset("reset");

    // Good frame, ready high
    c_ready = 1'b1; n_cv = 0; err0 = m_errs;
    send_frame(8'h03, 8'h5C, 8'hFA);
    idle(3);
    check_eq("good_cv_cycles", 32'(n_cv), 32'd1);
    check_eq("good_err", 32'(err_count), 32'(err0));

    // Wrong checksum (a plain good frame without the checksum feature)
    n_cv = 0; err0 = m_errs;
    send_frame(8'h03, 8'h5C, 8'h00);
    idle(3);
    check_eq("badchk_cv_cycles", 32'(n_cv), 32'((FRAME_LEN == 4) ? 0 : 1));
    check_eq("badchk_err", 32'(err_count), 32'(err0 + ((FRAME_LEN == 4) ? 1 : 0)));

    // Receiver error mid-frame, then a good frame
    err0 = m_errs; n_cv = 0;
    send_byte(8'hA5);
    send_err();
    idle(2);
    check_eq("rxerr_err", 32'(err_count), 32'(err0 + 1));
    send_frame(8'h07, 8'h11, 8'h07 ^ 8'h11 ^ 8'hA5);
    idle(2);
    check_eq("rxerr_next_cv", 32'(n_cv), 32'd1);

    // Inter-byte timeout, late byte ignored
    err0 = m_errs; n_cv = 0;
    send_byte(8'hA5);
    send_byte(8'h01);
    idle(TMO);
    check_eq("tmo_err", 32'(err_count), 32'(err0 + 1));
    send_byte(8'h22);
    idle(3);
    check_eq("tmo_late_err", 32'(err_count), 32'(err0 + 1));
    check_eq("tmo_cv_cycles", 32'(n_cv), 32'd0);

    // Back-pressure: ready low for 20 cycles
    n_cv = 0; c_ready = 1'b0;
    send_frame(8'h0C, 8'h9E, 8'h0C ^ 8'h9E ^ 8'hA5);
    idle(20);
    c_ready = 1'b1;
    tick();
    check_eq("bp_cv_cycles", 32'(n_cv), 32'd21);
    check_eq("bp_released", 32'(c_valid), 32'd0);

    // Reset mid-frame and during ISSUE
    send_byte(8'hA5);
    send_byte(8'h03);
    do_reset("rst_mid");
    idle(3);
    c_ready = 1'b0;
    send_frame(8'h05, 8'h66, 8'h05 ^ 8'h66 ^ 8'hA5);
    idle(2);
    do_reset("rst_issue");
    c_ready = 1'b1;
    idle(3);

    // Randomized traffic
    rand_ready = 1;
    for (int f = 0; f < 150; f++) begin
      repeat ($urandom_range(0, 2)) send_byte(8'($urandom));
      fb[0] = 8'hA5;
      fb[1] = 8'($urandom);
      fb[2] = 8'($urandom);
      fb[3] = fb[1] ^ fb[2] ^ 8'hA5;
      if ($urandom_range(0, 4) == 0) fb[3] = fb[3] ^ 8'h10;
      for (int i = 0; i < FRAME_LEN; i++) begin
        sel = $urandom_range(0, 39);
        gap = (sel == 0) ? TMO : (sel == 1) ? TMO - 1 : sel % 4;
        for (int g = 0; g < gap; g++) begin
          in_error_valid = ($urandom_range(0, 99) == 0);
          tick();
        end
        in_valid = 1'b1;
        in_data  = fb[i];
        in_error_valid = ($urandom_range(0, 39) == 0);
        tick();
      end
    end
    rand_ready = 0;
    c_ready = 1'b1;
    idle(TMO + 2);

    // Saturation of the abort counter
    for (int i = 0; i < 260; i++) begin
      send_byte(8'hA5);
      send_err();
    end
    check_eq("sat_ff", 32'(err_count), 32'hFF);
    send_byte(8'hA5);
    send_err();
    check_eq("sat_hold", 32'(err_count), 32'hFF);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
